// File: rtl/csr_file_if.sv
// CSR access port: request from the pipeline, registered read/illegal response back.
interface csr_file_if;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_no_wr;
    logic [31:0] csr_rdata;
    logic        csr_rvalid;
    logic        csr_illegal;

    modport master (
        output csr_op, csr_addr, csr_wdata, csr_no_wr,
        input  csr_rdata, csr_rvalid, csr_illegal
    );

    modport slave (
        input  csr_op, csr_addr, csr_wdata, csr_no_wr,
        output csr_rdata, csr_rvalid, csr_illegal
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file with trap/mret state updates and a registered read port.
// Define CSR_COUNTERS_EN to build the mcycle/minstret counters (B00/B80/B02/B82).
module csr_file #(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          CNT_W       = 64
) (
    input  logic        clk,
    input  logic        rst,
    csr_file_if.slave   csr,
    input  logic        trap_valid_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_tval_i,
    input  logic        mret_valid_i,
    input  logic        retire_i,
    input  logic        irq_sw_i,
    input  logic        irq_timer_i,
    input  logic        irq_ext_i,
    output logic [31:0] trap_vector_o,
    output logic [31:0] mepc_o,
    output logic        irq_take_o
);
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    logic        mie_q, mpie_q;
    logic [31:0] mie_en_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [31:0] rdata_q;
    logic        rvalid_q, illegal_q;

    logic [31:0] mip, mstatus, rd_val, csr_nv, vec_off;
    logic        impl, wr_req, illegal, wr_en, op_act;

`ifdef CSR_COUNTERS_EN
    logic [CNT_W-1:0] mcycle_q, minstret_q;
    logic [63:0]      mcycle_x, minstret_x;
    assign mcycle_x   = 64'(mcycle_q);
    assign minstret_x = 64'(minstret_q);
`endif

    assign mip     = {20'd0, irq_ext_i, 3'd0, irq_timer_i, 3'd0, irq_sw_i, 3'd0};
    assign mstatus = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
    assign op_act  = (csr.csr_op != OP_NONE);

    always_comb begin
        impl   = 1'b1;
        rd_val = 32'd0;
        case (csr.csr_addr)
            12'hF11, 12'hF12, 12'hF13: rd_val = 32'd0;
            12'hF14: rd_val = HART_ID;
            12'h300: rd_val = mstatus;
            12'h301: rd_val = 32'h4000_0100;
            12'h304: rd_val = mie_en_q;
            12'h305: rd_val = mtvec_q;
            12'h340: rd_val = mscratch_q;
            12'h341: rd_val = mepc_q;
            12'h342: rd_val = mcause_q;
            12'h343: rd_val = mtval_q;
            12'h344: rd_val = mip;
`ifdef CSR_COUNTERS_EN
            12'hB00: rd_val = mcycle_x[31:0];
            12'hB80: rd_val = mcycle_x[63:32];
            12'hB02: rd_val = minstret_x[31:0];
            12'hB82: rd_val = minstret_x[63:32];
`endif
            default: impl = 1'b0;
        endcase
    end

    always_comb begin
        case (csr.csr_op)
            OP_RW:   csr_nv = csr.csr_wdata;
            OP_RS:   csr_nv = rd_val | csr.csr_wdata;
            OP_RC:   csr_nv = rd_val & ~csr.csr_wdata;
            default: csr_nv = rd_val;
        endcase
    end

    // A suppressed RS/RC is a pure read, so it is legal even on read-only addresses.
    assign wr_req  = (csr.csr_op == OP_RW) || (op_act && !csr.csr_no_wr);
    assign illegal = op_act && (!impl || ((csr.csr_addr[11:10] == 2'b11) && wr_req));
    assign wr_en   = wr_req && !illegal && !trap_valid_i && !mret_valid_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mie_en_q   <= 32'd0;
            mtvec_q    <= MTVEC_RESET & ~32'h2;
            mscratch_q <= 32'd0;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mtval_q    <= 32'd0;
            rdata_q    <= 32'd0;
            rvalid_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            if (trap_valid_i) begin
                mepc_q   <= trap_pc_i & ~32'h3;
                mcause_q <= trap_cause_i;
                mtval_q  <= trap_tval_i;
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
            end else if (mret_valid_i) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end else if (wr_en) begin
                case (csr.csr_addr)
                    12'h300: begin
                        mie_q  <= csr_nv[3];
                        mpie_q <= csr_nv[7];
                    end
                    12'h304: mie_en_q   <= csr_nv & 32'h0000_0888;
                    12'h305: mtvec_q    <= csr_nv & ~32'h2;
                    12'h340: mscratch_q <= csr_nv;
                    12'h341: mepc_q     <= csr_nv & ~32'h3;
                    12'h342: mcause_q   <= csr_nv;
                    12'h343: mtval_q    <= csr_nv;
                    default: ;
                endcase
            end
            rvalid_q  <= op_act;
            illegal_q <= illegal;
            if (op_act) rdata_q <= rd_val;
        end
    end

`ifdef CSR_COUNTERS_EN
    // A write to either half replaces that cycle's increment for the whole counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (wr_en && csr.csr_addr == 12'hB00)
                mcycle_q <= CNT_W'({mcycle_x[63:32], csr_nv});
            else if (wr_en && csr.csr_addr == 12'hB80)
                mcycle_q <= CNT_W'({csr_nv, mcycle_x[31:0]});
            else
                mcycle_q <= mcycle_q + CNT_W'(1);

            if (wr_en && csr.csr_addr == 12'hB02)
                minstret_q <= CNT_W'({minstret_x[63:32], csr_nv});
            else if (wr_en && csr.csr_addr == 12'hB82)
                minstret_q <= CNT_W'({csr_nv, minstret_x[31:0]});
            else if (retire_i)
                minstret_q <= minstret_q + CNT_W'(1);
        end
    end
`else
    localparam int CNT_W_UNUSED = CNT_W;
    logic retire_unused;
    assign retire_unused = retire_i;
`endif

    assign vec_off       = (mtvec_q[0] && trap_cause_i[31]) ? ({1'b0, trap_cause_i[30:0]} << 2) : 32'd0;
    assign trap_vector_o = {mtvec_q[31:2], 2'b00} + vec_off;
    assign mepc_o        = mepc_q;
    assign irq_take_o    = mie_q && |(mie_en_q & mip);

    assign csr.csr_rdata   = rdata_q;
    assign csr.csr_rvalid  = rvalid_q;
    assign csr.csr_illegal = illegal_q;
endmodule

// File: tb/tb_csr_file.sv
// Randomized scoreboard bench for csr_file against a register-level reference model.
module tb_csr_file;
    localparam logic [31:0] HART  = 32'd3;
    localparam logic [31:0] MTR   = 32'h0000_0401;
    localparam int          CNTW  = 40;
    localparam logic [63:0] CMASK = (64'd1 << CNTW) - 64'd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csr_file_if bus ();
    logic        trap_valid = 0, mret_valid = 0, retire = 0;
    logic [31:0] trap_cause = 0, trap_pc = 0, trap_tval = 0;
    logic [2:0]  irq = 0;
    logic [31:0] trap_vector, mepc_out;
    logic        irq_take;

    csr_file #(.HART_ID(HART), .MTVEC_RESET(MTR), .CNT_W(CNTW)) dut (
        .clk(clk), .rst(rst), .csr(bus.slave),
        .trap_valid_i(trap_valid), .trap_cause_i(trap_cause), .trap_pc_i(trap_pc),
        .trap_tval_i(trap_tval), .mret_valid_i(mret_valid), .retire_i(retire),
        .irq_sw_i(irq[0]), .irq_timer_i(irq[1]), .irq_ext_i(irq[2]),
        .trap_vector_o(trap_vector), .mepc_o(mepc_out), .irq_take_o(irq_take)
    );

    typedef struct packed { logic v; logic ill; logic [31:0] rd; } exp_t;
    exp_t expq[$];
    int tests = 0, fails = 0;

    // reference model state
    logic        m_mie, m_mpie;
    logic [31:0] m_mien, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip;
    logic [63:0] m_cyc, m_ins;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_mie = 0; m_mpie = 0; m_mien = 0; m_mtvec = MTR & ~32'h2;
        m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0;
    endfunction

    function automatic void model_read(input logic [11:0] a, output logic impl, output logic [31:0] v);
        impl = 1; v = 0;
        case (a)
            12'hF11, 12'hF12, 12'hF13: v = 0;
            12'hF14: v = HART;
            12'h300: v = 32'h1800 | (m_mpie ? 32'h80 : 0) | (m_mie ? 32'h8 : 0);
            12'h301: v = 32'h4000_0100;
            12'h304: v = m_mien;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: v = m_mip;
`ifdef CSR_COUNTERS_EN
            12'hB00: v = m_cyc[31:0];
            12'hB80: v = m_cyc[63:32];
            12'hB02: v = m_ins[31:0];
            12'hB82: v = m_ins[63:32];
`endif
            default: impl = 0;
        endcase
    endfunction

    function automatic void model_write(input logic [11:0] a, input logic [31:0] val);
        case (a)
            12'h300: begin m_mie = val[3]; m_mpie = val[7]; end
            12'h304: m_mien = val & 32'h888;
            12'h305: m_mtvec = val & ~32'h2;
            12'h340: m_mscratch = val;
            12'h341: m_mepc = val & ~32'h3;
            12'h342: m_mcause = val;
            12'h343: m_mtval = val;
            12'hB00: m_cyc = {m_cyc[63:32], val} & CMASK;
            12'hB80: m_cyc = {val, m_cyc[31:0]} & CMASK;
            12'hB02: m_ins = {m_ins[63:32], val} & CMASK;
            12'hB82: m_ins = {val, m_ins[31:0]} & CMASK;
            default: ;
        endcase
    endfunction

    task automatic step(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd, input logic nw);
        logic impl, wreq, ill, wen, cw, iw;
        logic [31:0] old, nv, tv_exp;
        exp_t e;
        bus.csr_op = op; bus.csr_addr = a; bus.csr_wdata = wd; bus.csr_no_wr = nw;
        m_mip = (irq[0] ? 32'h8 : 0) | (irq[1] ? 32'h80 : 0) | (irq[2] ? 32'h800 : 0);
        #1;
        tv_exp = m_mtvec & ~32'h3;
        if (m_mtvec[0] && trap_cause[31]) tv_exp = tv_exp + (trap_cause & 32'h7FFF_FFFF) * 4;
        chk("trap_vector", trap_vector, tv_exp);
        chk("irq_take", {31'd0, irq_take}, {31'd0, m_mie && ((m_mien & m_mip) != 0)});
        chk("mepc_out", mepc_out, m_mepc);

        model_read(a, impl, old);
        wreq = (op == 2'b01) || (op != 2'b00 && !nw);
        ill  = (op != 2'b00) && (!impl || (a[11:10] == 2'b11 && wreq));
        case (op)
            2'b01:   nv = wd;
            2'b10:   nv = old | wd;
            2'b11:   nv = old & ~wd;
            default: nv = old;
        endcase
        e.v = (op != 2'b00); e.ill = ill; e.rd = old;
        wen = wreq && !ill && !trap_valid && !mret_valid;
        cw  = wen && (a == 12'hB00 || a == 12'hB80);
        iw  = wen && (a == 12'hB02 || a == 12'hB82);
        if (trap_valid) begin
            m_mepc = trap_pc & ~32'h3; m_mcause = trap_cause; m_mtval = trap_tval;
            m_mpie = m_mie; m_mie = 0;
        end else if (mret_valid) begin
            m_mie = m_mpie; m_mpie = 1;
        end else if (wen) begin
            model_write(a, nv);
        end
        if (!cw) m_cyc = (m_cyc + 1) & CMASK;
        if (!iw && retire) m_ins = (m_ins + 1) & CMASK;

        @(posedge clk);
        expq.push_back(e);
        #1;
        trap_valid = 0; mret_valid = 0; retire = 0;
        bus.csr_op = 2'b00;
    endtask

    task automatic do_reset(input logic with_trap);
        @(negedge clk);
        trap_valid = with_trap; trap_pc = 32'hDEAD_BEEC; trap_cause = 32'd5;
        bus.csr_op = 2'b01; bus.csr_addr = 12'h340; bus.csr_wdata = 32'h5555_AAAA; bus.csr_no_wr = 0;
        rst = 1;
        #1;
        trap_valid = 0; bus.csr_op = 2'b00;
        @(posedge clk); @(posedge clk); #1;
        expq.delete();
        model_reset();
        chk("rst_rvalid", {31'd0, bus.csr_rvalid}, 32'd0);
        chk("rst_illegal", {31'd0, bus.csr_illegal}, 32'd0);
        chk("rst_rdata", bus.csr_rdata, 32'd0);
        chk("rst_mepc", mepc_out, 32'd0);
        rst = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("rvalid", {31'd0, bus.csr_rvalid}, {31'd0, e.v});
                if (e.v) begin
                    chk("illegal", {31'd0, bus.csr_illegal}, {31'd0, e.ill});
                    chk("rdata", bus.csr_rdata, e.rd);
                end
            end else if (!rst) begin
                chk("idle_rvalid", {31'd0, bus.csr_rvalid}, 32'd0);
            end
        end
    end

    logic [11:0] addrs [20];
    initial begin
        addrs = '{12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h300, 12'h301, 12'h304, 12'h305,
                  12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7C0, 12'hB00, 12'hB80,
                  12'hB02, 12'hB82, 12'h123, 12'hFFF};
        bus.csr_op = 0; bus.csr_addr = 0; bus.csr_wdata = 0; bus.csr_no_wr = 0;
        do_reset(1'b0);

        // mtvec write returns reset value, bit 1 masked
        step(2'b01, 12'h305, 32'h8000_0103, 0);
        step(2'b10, 12'h305, 32'h0, 1);
        // vectored trap
        step(2'b01, 12'h305, 32'h0000_0101, 0);
        step(2'b01, 12'h300, 32'h8, 0);
        trap_valid = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h0000_2002; trap_tval = 32'h77;
        step(2'b00, 12'h0, 32'h0, 0);
        step(2'b10, 12'h342, 32'h0, 1);
        step(2'b10, 12'h300, 32'h0, 1);
        // trap beats a same-cycle write, then mret restores MIE
        trap_valid = 1; trap_cause = 32'd2; trap_pc = 32'h0000_4444; trap_tval = 32'h0;
        step(2'b01, 12'h341, 32'h1234, 0);
        step(2'b10, 12'h341, 32'h0, 1);
        mret_valid = 1;
        step(2'b00, 12'h0, 32'h0, 0);
        step(2'b10, 12'h300, 32'h0, 1);
        // legality of the read-only and unimplemented spaces
        step(2'b10, 12'hF11, 32'hFFFF_FFFF, 1);
        step(2'b01, 12'hF11, 32'h1, 0);
        step(2'b10, 12'h7C0, 32'h0, 1);
        step(2'b10, 12'hF14, 32'h0, 1);
`ifdef CSR_COUNTERS_EN
        step(2'b01, 12'hB00, 32'hFFFF_FFFF, 0);
        step(2'b01, 12'hB80, 32'h0, 0);
        step(2'b10, 12'hB80, 32'h0, 1);
        step(2'b10, 12'hB80, 32'h0, 1);
        step(2'b11, 12'hB82, 32'h0, 1);
`else
        step(2'b10, 12'hB00, 32'h0, 1);
`endif
        // interrupt enable path
        step(2'b01, 12'h300, 32'h8, 0);
        step(2'b01, 12'h304, 32'h80, 0);
        irq = 3'b010;
        step(2'b10, 12'h344, 32'h0, 1);
        step(2'b01, 12'h304, 32'h0, 0);
        step(2'b00, 12'h0, 32'h0, 0);
        irq = 0;

        // reset while a trap and a write are pending
        do_reset(1'b1);
        step(2'b10, 12'h341, 32'h0, 1);
        step(2'b10, 12'h340, 32'h0, 1);

        for (int i = 0; i < 600; i++) begin
            irq        = 3'($urandom);
            retire     = 1'($urandom);
            trap_valid = ($urandom_range(0, 15) == 0);
            mret_valid = ($urandom_range(0, 15) == 0);
            trap_cause = $urandom; trap_pc = $urandom; trap_tval = $urandom;
            step(2'($urandom), addrs[$urandom_range(0, 19)],
                 ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, 1'($urandom));
        end
        irq = 0;
        step(2'b00, 12'h0, 32'h0, 0);
        @(negedge clk); #1;
        chk("queue_drained", expq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter HART_ID, default 0, value read from mhartid.
REQ-002 SHALL have parameter MTVEC_RESET, default 32'h0000_0000, mtvec reset value.
REQ-003 SHALL have parameter CNT_W, default 64, mcycle/minstret width (legal values: 33..64).
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 csr_op  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear).
REQ-007 csr_addr  in  12  CSR address; csr_wdata  in  32  source operand.
REQ-008 csr_no_wr  in  1  source is x0/zero-imm; suppresses the write for RS/RC.
REQ-009 csr_rdata  out  32  registered old value; csr_rvalid  out  1  rdata valid; csr_illegal  out  1  registered illegal flag.
REQ-010 trap_valid  in  1; trap_cause  in  32; trap_pc  in  32; trap_tval  in  32.
REQ-011 mret_valid  in  1  mret commits this cycle; retire  in  1  one instruction retired.
REQ-012 irq_sw, irq_timer, irq_ext  in  1 each, level interrupt sources.
REQ-013 trap_vector  out  32; mepc_out  out  32; irq_take  out  1  (combinational).

Function
REQ-014 SHALL implement mvendorid/marchid/mimpid (F11-F13, read 0), mhartid (F14), mstatus 300, misa 301 (32'h4000_0100, read-only), mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344.
REQ-015 SHALL return the pre-write CSR value on csr_rdata, with csr_rvalid high, one cycle after csr_op!=00; csr_rvalid low otherwise.
REQ-016 SHALL compute new value = wdata (RW), old|wdata (RS), old&~wdata (RC); RS/RC with csr_no_wr SHALL not write.
REQ-017 SHALL flag csr_illegal (one cycle later, no state change) for an unimplemented address, or a write to addr[11:10]==11 unless it is suppressed RS/RC.
REQ-018 mstatus: only MIE[3] and MPIE[7] writable; MPP[12:11] reads 11; other bits 0.
REQ-019 mie: bits 3,7,11 writable, others 0; mip: bits 3,7,11 = irq_sw, irq_timer, irq_ext, writes ignored.
REQ-020 mtvec bit 1 reads 0; mepc bits [1:0] read 0; mscratch, mcause, mtval fully writable.
REQ-021 trap_valid SHALL next cycle set mepc=trap_pc, mcause=trap_cause, mtval=trap_tval, MPIE=MIE, MIE=0.
REQ-022 mret_valid SHALL next cycle set MIE=MPIE, MPIE=1.
REQ-023 Same-cycle priority SHALL be trap > mret > CSR write; the lower-priority update is dropped (CSR read data still returned).
REQ-024 trap_vector = {mtvec[31:2],2'b00}, plus 4*trap_cause[30:0] when mtvec[0]=1 and trap_cause[31]=1.
REQ-025 irq_take = MIE & |(mie & mip).
REQ-026 mepc_out SHALL reflect the current mepc register.

Reset
REQ-027 On rst SHALL set mstatus MIE=0, MPIE=0; mie=0; mtvec=MTVEC_RESET; mscratch, mepc, mcause, mtval=0; csr_rdata=0; csr_rvalid=0; csr_illegal=0; counters=0.
REQ-028 Reset asserted mid-operation SHALL discard any in-flight write or trap update immediately.

Configuration
REQ-029 With CSR_COUNTERS_EN defined, SHALL implement mcycle B00/mcycleh B80 and minstret B02/minstreth B82 (CNT_W bits, upper bits read 0): mcycle +1 every cycle, minstret +1 on retire, wrapping at 2^CNT_W; a CSR write to a half SHALL take precedence over that cycle's increment.
REQ-030 Without CSR_COUNTERS_EN, SHALL omit the counters, and B00/B80/B02/B82 SHALL be illegal.

Verification
REQ-031 After reset, RW 305 with wdata 32'h8000_0103 -> rdata=MTVEC_RESET; subsequent read -> 32'h8000_0101.
REQ-032 mtvec=32'h100 with mode 1, trap_cause 32'h8000_0007 -> trap_vector 32'h11C; next cycle, mcause read 32'h8000_0007 and MIE=0, MPIE=old MIE.
REQ-033 Same-cycle trap_valid and RW 341 with 32'h1234 -> mepc=trap_pc, write dropped; mret with MPIE=1 -> MIE=1.
REQ-034 RS to F11 with csr_no_wr=1 -> rdata 0, illegal 0; RW to F11 -> illegal 1; read of 7C0 -> illegal 1.
REQ-035 With CSR_COUNTERS_EN, write mcycle=32'hFFFF_FFFF, mcycleh=0 -> two cycles later mcycleh=1; without it, read B00 -> illegal 1.
REQ-036 MIE=1, mie=32'h80, assert irq_timer -> irq_take=1 and mip reads 32'h80; clear mie -> irq_take=0.
